note_spi_frame_rx: RTL
======================

Name: note_spi_frame_rx

Overview:
- Upstream feeder for the note display path: receives the PIC's note-bitmap byte over SPI.
- SPI lines are oversampled in the 25.175 MHz pixel-clock domain; no second clock.
- Each received byte is held pending and committed to the `notes` output only at the start of vsync, so the staff image never changes mid-frame.
- Output `notes[7:0]` drives the per-note enables of the music-image generator.

Parameters:
- SYNC_STAGES, 2, flops in each input synchroniser chain (legal values 2..4).
- NOTE_BITS, 8, payload bits per SPI frame.
- RESET_NOTES, 8'h00, value loaded into `notes` on reset.

Ports:
- vgaclk  input  1  pixel clock; all logic is on its rising edge.
- reset  input  1  asynchronous, active-high reset.
- sck  input  1  SPI clock from PIC; asynchronous to vgaclk.
- sdi  input  1  SPI data from PIC; MSB first; sampled on sck rising edge.
- sel  input  1  active-high frame select from PIC; asynchronous.
- vsync  input  1  active-low vertical sync from the VGA controller; same clock domain.
- notes  output  NOTE_BITS  committed note bitmap; bit 7 = leftmost note.
- frame_tick  output  1  one-cycle pulse when `notes` is updated.
- frame_err  output  1  sticky; set on a short frame; cleared only by reset.

Behaviour:
- Reset (asynchronous, active-high):
  - notes=RESET_NOTES, frame_tick=0, frame_err=0.
  - Shift register, bit counter and pending flag are cleared; all synchroniser flops are cleared; state=IDLE.
- Synchronisers: sck, sdi and sel each pass through SYNC_STAGES flops.
- Edge detection uses one extra flop on synchronised sck; rise = s_sck & ~s_sck_d.
- Input constraints: sck high and low phases must each be ≥2 vgaclk periods. Faster sck is unsupported; no detection is required.
- State machine:
  - IDLE: s_sel=1 → SHIFT; bitcnt=0.
  - SHIFT: on rise, shreg={shreg[NOTE_BITS-2:0], s_sdi} and bitcnt++.
    - When bitcnt reaches NOTE_BITS: pend_data<=shifted value, pend_flag<=1, → WAIT_DESEL.
    - If s_sel=0 with 0<bitcnt<NOTE_BITS: frame_err<=1, byte discarded, → IDLE.
    - If s_sel=0 with bitcnt=0: → IDLE silently.
  - WAIT_DESEL: further sck edges are ignored, with no error. s_sel=0 → IDLE.
- Pending: a newer completed byte overwrites pend_data before commit (last byte wins).
- Commit:
  - vsync falling edge (vsync_d=1 & vsync=0) with pend_flag=1 → notes<=pend_data, pend_flag<=0, frame_tick=1 for that cycle.
  - Latency: notes changes on the cycle after the vsync edge is seen.
  - With pend_flag=0, no change and no tick.
- Simultaneous commit and byte completion in the same cycle: commit uses the old pend_data; the new byte sets pend_flag=1 and commits at the next vsync edge.
- Reset mid-frame: the partial byte is lost; the next frame starts cleanly once sel is seen low, then high.
- sel already high as reset releases: first enter IDLE, then SHIFT. Bits clocked before reset release are lost, which can produce frame_err on a later deassert.

Optional Feature:
- NOTE_SPI_PARITY_EN defined:
  - Frame is NOTE_BITS+1 bits; the last bit is odd parity over the payload.
  - On a parity mismatch the byte is dropped (pend unchanged) and frame_err is set.
  - A 9th rise is required before entering WAIT_DESEL.
- Undefined: frame is exactly NOTE_BITS bits; no parity logic exists.

Decomposition:
- Package note_spi_pkg:
  - NOTE_BITS constant.
  - Typedef notes_t (logic [NOTE_BITS-1:0]).
  - Enum rx_state_t {IDLE, SHIFT, WAIT_DESEL}.
  - Localparam for the bit-counter width.
- Sub-module sync_ff: parameterised SYNC_STAGES single-bit synchroniser with async active-high reset. It is instantiated three times (sck, sdi, sel).

Test Plan:
- Reset, then send 8'b1010_0101 with sck=vgaclk/8, then a vsync low pulse → notes=8'hA5 one cycle after the vsync fall; frame_tick high exactly 1 cycle; frame_err=0.
- Send 8'h3C, then 8'hF0 before any vsync → at the next vsync fall notes=8'hF0; exactly one frame_tick.
- Send 5 bits, then drop sel → frame_err=1 and stays 1; notes unchanged at the next vsync; a subsequent full 8'h81 frame commits 8'h81.
- Complete a byte 8'h0F on the same cycle as the vsync fall while 8'h11 is pending → notes=8'h11 now, then 8'h0F at the following vsync fall.
- 12 sck rises in one sel window with bits 8'hC3 then 4'hF → notes=8'hC3; frame_err=0.
- With NOTE_SPI_PARITY_EN: payload 8'h01 with parity bit 0 → accepted (notes=8'h01). Payload 8'h01 with parity bit 1 → frame_err=1 and notes unchanged.

Source files
------------

// File: rtl/note_spi_pkg.sv
// ============================================================================
//  Module      : note_spi_pkg
//  Description : Shared types and constants for the note-bitmap SPI receiver.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package note_spi_pkg;

    localparam int NOTE_BITS = 8;

    // Counter must reach NOTE_BITS+1 when the parity bit is enabled
    localparam int BITCNT_W  = $clog2(NOTE_BITS + 2);

    typedef logic [NOTE_BITS-1:0] notes_t;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        SHIFT      = 2'd1,
        WAIT_DESEL = 2'd2
    } rx_state_t;

endpackage

`default_nettype wire

// File: rtl/note_spi_frame_rx_sync_ff.sv
// ============================================================================
//  Module      : sync_ff
//  Description : Single-bit multi-flop synchroniser, async active-high reset.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module sync_ff #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic i_d,
    output logic o_q
);

    logic [SYNC_STAGES-1:0] r_chain;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_chain <= '0;
        end else begin
            r_chain <= {r_chain[SYNC_STAGES-2:0], i_d};
        end
    end

    assign o_q = r_chain[SYNC_STAGES-1];

endmodule

`default_nettype wire

// File: rtl/note_spi_frame_rx.sv
// ============================================================================
//  Module      : note_spi_frame_rx
//  Description : Oversampled SPI receiver for the note bitmap; commits each
//                byte to `notes` on the vsync falling edge.
//                Optional odd-parity frame bit: define NOTE_SPI_PARITY_EN.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module note_spi_frame_rx #(
    parameter int                   SYNC_STAGES = 2,
    parameter int                   NOTE_BITS   = note_spi_pkg::NOTE_BITS,
    parameter logic [NOTE_BITS-1:0] RESET_NOTES = '0
) (
    input  logic                 vgaclk,
    input  logic                 reset,
    input  logic                 sck,
    input  logic                 sdi,
    input  logic                 sel,
    input  logic                 vsync,
    output logic [NOTE_BITS-1:0] notes,
    output logic                 frame_tick,
    output logic                 frame_err
);

    import note_spi_pkg::*;

    localparam int CNT_W = $clog2(NOTE_BITS + 2);

`ifdef NOTE_SPI_PARITY_EN
    localparam int FRAME_BITS = NOTE_BITS + 1;
    localparam int SHREG_W    = NOTE_BITS;
`else
    // Last payload bit is taken straight from the synchroniser, so the
    // shift register only needs to hold the earlier bits.
    localparam int FRAME_BITS = NOTE_BITS;
    localparam int SHREG_W    = NOTE_BITS - 1;
`endif

    localparam logic [1:0] C_IDLE       = IDLE;
    localparam logic [1:0] C_SHIFT      = SHIFT;
    localparam logic [1:0] C_WAIT_DESEL = WAIT_DESEL;

    logic                 w_s_sck;
    logic                 w_s_sdi;
    logic                 w_s_sel;

    logic                 r_sck_d;
    logic                 r_vsync_d;
    logic [1:0]           r_state;
    logic [CNT_W-1:0]     r_bitcnt;
    logic [SHREG_W-1:0]   r_shreg;
    logic [NOTE_BITS-1:0] r_pend_data;
    logic                 r_pend_flag;
    logic [NOTE_BITS-1:0] r_notes;
    logic                 r_tick;
    logic                 r_err;

    logic                 w_rise;
    logic                 w_commit;
    logic                 w_last_rise;
    logic                 w_parity_ok;
    logic                 w_complete;
    logic                 w_short;
    logic                 w_set_err;
    logic [SHREG_W-1:0]   w_next_shreg;
    logic [NOTE_BITS-1:0] w_payload;

    sync_ff #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sck (
        .clk (vgaclk),
        .rst (reset),
        .i_d (sck),
        .o_q (w_s_sck)
    );

    sync_ff #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sdi (
        .clk (vgaclk),
        .rst (reset),
        .i_d (sdi),
        .o_q (w_s_sdi)
    );

    sync_ff #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sel (
        .clk (vgaclk),
        .rst (reset),
        .i_d (sel),
        .o_q (w_s_sel)
    );

    always_comb begin
        w_rise       = w_s_sck & ~r_sck_d;
        w_commit     = r_vsync_d & ~vsync & r_pend_flag;
        w_next_shreg = {r_shreg[SHREG_W-2:0], w_s_sdi};
        w_last_rise  = (r_state == C_SHIFT) & w_s_sel & w_rise &
                       (r_bitcnt == CNT_W'(FRAME_BITS - 1));
`ifdef NOTE_SPI_PARITY_EN
        w_payload    = r_shreg;
        w_parity_ok  = ^{r_shreg, w_s_sdi};
`else
        w_payload    = {r_shreg, w_s_sdi};
        w_parity_ok  = 1'b1;
`endif
        w_complete   = w_last_rise & w_parity_ok;
        w_short      = (r_state == C_SHIFT) & ~w_s_sel & (r_bitcnt != '0);
        w_set_err    = w_short | (w_last_rise & ~w_parity_ok);
    end

    always_ff @(posedge vgaclk or posedge reset) begin
        if (reset) begin
            r_sck_d   <= 1'b0;
            r_vsync_d <= 1'b0;
        end else begin
            r_sck_d   <= w_s_sck;
            r_vsync_d <= vsync;
        end
    end

    always_ff @(posedge vgaclk or posedge reset) begin
        if (reset) begin
            r_state  <= C_IDLE;
            r_bitcnt <= '0;
            r_shreg  <= '0;
        end else begin
            case (r_state)
                C_IDLE: begin
                    if (w_s_sel) begin
                        r_state  <= C_SHIFT;
                        r_bitcnt <= '0;
                    end
                end
                C_SHIFT: begin
                    if (!w_s_sel) begin
                        r_state <= C_IDLE;
                    end else if (w_rise) begin
                        r_shreg  <= w_next_shreg;
                        r_bitcnt <= r_bitcnt + CNT_W'(1);
                        if (w_last_rise) begin
                            r_state <= C_WAIT_DESEL;
                        end
                    end
                end
                C_WAIT_DESEL: begin
                    if (!w_s_sel) begin
                        r_state <= C_IDLE;
                    end
                end
                default: begin
                    r_state <= C_IDLE;
                end
            endcase
        end
    end

    // A byte finishing in the commit cycle wins the flag; commit takes old data
    always_ff @(posedge vgaclk or posedge reset) begin
        if (reset) begin
            r_pend_data <= '0;
            r_pend_flag <= 1'b0;
        end else if (w_complete) begin
            r_pend_data <= w_payload;
            r_pend_flag <= 1'b1;
        end else if (w_commit) begin
            r_pend_flag <= 1'b0;
        end
    end

    always_ff @(posedge vgaclk or posedge reset) begin
        if (reset) begin
            r_notes <= RESET_NOTES;
            r_tick  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_tick <= w_commit;
            if (w_commit) begin
                r_notes <= r_pend_data;
            end
            if (w_set_err) begin
                r_err <= 1'b1;
            end
        end
    end

    assign notes      = r_notes;
    assign frame_tick = r_tick;
    assign frame_err  = r_err;

endmodule

`default_nettype wire
